// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter that shares one 16-bit fifo write port between four producers.
// A locked winner may keep the port for up to MAX_BURST consecutive words.
module fifo_push_arbiter #(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4,
  parameter int DEBUG     = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      lock,
  input  logic [16*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      grant,
  output logic                 fifo_push,
  output logic [15:0]          fifo_data,
  input  logic                 fifo_full,
  input  logic                 flush_in,
  output logic                 fifo_flush,
  output logic                 busy,
  output logic                 stall
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_e;

  localparam logic [3:0] BURST_CAP = 4'(MAX_BURST);
  localparam bit         LOCK_EN   = (MAX_BURST > 1);

  state_e          state_q, state_d;
  logic [1:0]      last_q, last_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [1:0]      owner_q, owner_d;
  logic            busy_q;

  logic            accept_s;
  logic            found_s;
  logic [1:0]      winner_s;
  logic [NREQ-1:0] grant_s;
  logic [15:0]     data_s;

  assign accept_s = !reset && !flush_in && !fifo_full;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    found_s  = 1'b0;
    winner_s = last_q;
    for (int k = 0; k < NREQ; k++) begin
      if (!found_s && req[last_q + 2'(k + 1)]) begin
        found_s  = 1'b1;
        winner_s = last_q + 2'(k + 1);
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Next-state and grant decode.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    grant_s = '0;
    if (flush_in) begin
      state_d = ST_IDLE;
      cnt_d   = 4'd0;
    end else if (state_q == ST_OWN && lock[owner_q]) begin
      if (accept_s && req[owner_q]) begin
        grant_s[owner_q] = 1'b1;
        last_d           = owner_q;
        if (cnt_q + 4'd1 == BURST_CAP) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end else begin
        state_d = ST_OWN;
      end
    end else begin
      // Released or never locked: plain round-robin for this cycle.
      state_d = ST_IDLE;
      cnt_d   = 4'd0;
      if (accept_s && found_s) begin
        grant_s[winner_s] = 1'b1;
        last_d            = winner_s;
        if (lock[winner_s] && LOCK_EN) begin
          state_d = ST_OWN;
          owner_d = winner_s;
          cnt_d   = 4'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // Word mux for the granted requester.
  always_comb begin
    data_s = 16'h0000;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_s[i]) begin
        data_s = req_data[i*16 +: 16];
      end else begin
        data_s = data_s;
      end
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      last_q  <= 2'd3;
      cnt_q   <= 4'd0;
      owner_q <= 2'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      busy_q  <= (state_d == ST_OWN);
    end
  end

  assign grant      = grant_s;
  assign fifo_push  = |grant_s;
  assign fifo_data  = data_s;
  assign fifo_flush = flush_in && !reset;
  assign busy       = busy_q;
  assign stall      = (|req) && fifo_full && !flush_in;

endmodule
